mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller arbitrating instruction fetch and load/store requests
// Ports:
//   clk, rst (async active-low), rdy (global enable, freezes all state when low)
//   if_req_flag/if_req_pc          -> if_done_flag/if_inst        : 4-byte instruction fetch
//   lsb_req_flag/wr/addr/size/data -> lsb_done_flag/lsb_rdata     : byte/half/word load or store
//   rob_flush                      : drops pending or in-flight fetch, never touches LSB work
//   mem_din/mem_dout/mem_a/mem_wr  : RAM with one-cycle read latency
//   io_buffer_full                 : back-pressure for stores into the IO window (addr[17:16]==2'b11)
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_flag,
    input  logic [31:0] if_req_pc,
    output logic        if_done_flag,
    output logic [31:0] if_inst,
    input  logic        lsb_req_flag,
    input  logic        lsb_req_wr,
    input  logic [31:0] lsb_req_addr,
    input  logic [1:0]  lsb_req_size,
    input  logic [31:0] lsb_req_data,
    output logic        lsb_done_flag,
    output logic [31:0] lsb_rdata,
    input  logic        rob_flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t      state_q, state_d;
    logic        if_pend_q, if_pend_d, lsb_pend_q, lsb_pend_d, lsb_wr_q, lsb_wr_d;
    logic [31:0] if_pc_q, if_pc_d, lsb_addr_q, lsb_addr_d, lsb_data_q, lsb_data_d;
    logic [1:0]  lsb_size_q, lsb_size_d;
    logic        last_if_q, last_if_d, srv_if_q, srv_if_d;
    logic [2:0]  len_q, len_d, cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d, mem_a_q, mem_a_d, if_inst_q, if_inst_d, lsb_rdata_q, lsb_rdata_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
    logic        fin, if_busy, lsb_busy, io_hold, if_ok, lsb_ok, gnt_if, gnt_lsb;
    logic [2:0]  lsb_len;
    logic [1:0]  bi;

    assign if_done_flag  = if_done_q;
    assign if_inst       = if_inst_q;
    assign lsb_done_flag = lsb_done_q;
    assign lsb_rdata     = lsb_rdata_q;
    assign mem_dout      = mem_dout_q;
    assign mem_a         = mem_a_q;
    assign mem_wr        = mem_wr_q;

    // fin marks the edge on which the current transfer ends; a request of the
    // finishing type on that edge is accepted rather than ignored
    assign fin      = (state_q == READ) ? (cnt_q == len_q) : (state_q == WRITE) && (cnt_q + 3'd1 == len_q);
    assign if_busy  = (state_q == READ) && srv_if_q && !fin;
    assign lsb_busy = (state_q != IDLE) && !srv_if_q && !fin;
    assign io_hold  = lsb_wr_q && (lsb_addr_q[17:16] == 2'b11) && io_buffer_full;
    assign if_ok    = if_pend_q && !rob_flush;
    assign lsb_ok   = lsb_pend_q && !io_hold;
    assign gnt_lsb  = (state_q == IDLE) && lsb_ok && (!if_ok || last_if_q);
    assign gnt_if   = (state_q == IDLE) && if_ok && !gnt_lsb;
    assign lsb_len  = (lsb_size_q == 2'd0) ? 3'd1 : (lsb_size_q == 2'd1) ? 3'd2 : 3'd4;
    // read data lags the address by two edges, so byte cnt-1 arrives now
    assign bi       = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d     = state_q;
        if_pend_d   = if_pend_q;
        if_pc_d     = if_pc_q;
        lsb_pend_d  = lsb_pend_q;
        lsb_wr_d    = lsb_wr_q;
        lsb_addr_d  = lsb_addr_q;
        lsb_size_d  = lsb_size_q;
        lsb_data_d  = lsb_data_q;
        last_if_d   = last_if_q;
        srv_if_d    = srv_if_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_inst_d   = if_inst_q;
        lsb_rdata_d = lsb_rdata_q;
        if_done_d   = 1'b0;
        lsb_done_d  = 1'b0;
        if (gnt_if) if_pend_d = 1'b0;
        if (if_req_flag && !if_pend_q && !if_busy) begin
            if_pend_d = 1'b1;
            if_pc_d   = if_req_pc;
        end
        if (rob_flush) if_pend_d = 1'b0;
        if (gnt_lsb) lsb_pend_d = 1'b0;
        if (lsb_req_flag && !lsb_pend_q && !lsb_busy) begin
            lsb_pend_d = 1'b1;
            lsb_wr_d   = lsb_req_wr;
            lsb_addr_d = lsb_req_addr;
            lsb_size_d = lsb_req_size;
            lsb_data_d = lsb_req_data;
        end
        if (state_q == IDLE) begin
            mem_a_d  = 32'h0;
            mem_wr_d = 1'b0;
            cnt_d    = 3'd0;
            if (gnt_if) begin
                state_d   = READ;
                srv_if_d  = 1'b1;
                last_if_d = 1'b1;
                len_d     = 3'd4;
                buf_d     = 32'h0;
                mem_a_d   = if_pc_q;
            end else if (gnt_lsb) begin
                state_d   = lsb_wr_q ? WRITE : READ;
                srv_if_d  = 1'b0;
                last_if_d = 1'b0;
                len_d     = lsb_len;
                mem_a_d   = lsb_addr_q;
                mem_wr_d  = lsb_wr_q;
                // stores shift the data out a byte per cycle; loads start from zero for zero-extension
                mem_dout_d = lsb_wr_q ? lsb_data_q[7:0] : mem_dout_q;
                buf_d      = lsb_wr_q ? {8'h0, lsb_data_q[31:8]} : 32'h0;
            end
        end else if (state_q == READ) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < len_q) mem_a_d = mem_a_q + 32'd1;
            if (cnt_q != 3'd0) buf_d[{bi, 3'b000} +: 8] = mem_din;
            if (fin) begin
                state_d     = IDLE;
                mem_a_d     = 32'h0;
                if_done_d   = srv_if_q;
                lsb_done_d  = !srv_if_q;
                if_inst_d   = srv_if_q ? buf_d : if_inst_q;
                lsb_rdata_d = srv_if_q ? lsb_rdata_q : buf_d;
            end
            if (rob_flush && srv_if_q) begin
                state_d   = IDLE;
                mem_a_d   = 32'h0;
                if_done_d = 1'b0;
                if_inst_d = if_inst_q;
            end
        end else begin
            cnt_d = cnt_q + 3'd1;
            if (fin) begin
                state_d    = IDLE;
                mem_a_d    = 32'h0;
                mem_wr_d   = 1'b0;
                lsb_done_d = 1'b1;
            end else begin
                mem_a_d    = mem_a_q + 32'd1;
                mem_dout_d = buf_q[7:0];
                buf_d      = {8'h0, buf_q[31:8]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            if_pend_q   <= 1'b0;
            if_pc_q     <= 32'h0;
            lsb_pend_q  <= 1'b0;
            lsb_wr_q    <= 1'b0;
            lsb_addr_q  <= 32'h0;
            lsb_size_q  <= 2'd0;
            lsb_data_q  <= 32'h0;
            last_if_q   <= 1'b1;
            srv_if_q    <= 1'b0;
            len_q       <= 3'd0;
            cnt_q       <= 3'd0;
            buf_q       <= 32'h0;
            mem_a_q     <= 32'h0;
            mem_dout_q  <= 8'h0;
            mem_wr_q    <= 1'b0;
            if_inst_q   <= 32'h0;
            lsb_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            lsb_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            if_pend_q   <= if_pend_d;
            if_pc_q     <= if_pc_d;
            lsb_pend_q  <= lsb_pend_d;
            lsb_wr_q    <= lsb_wr_d;
            lsb_addr_q  <= lsb_addr_d;
            lsb_size_q  <= lsb_size_d;
            lsb_data_q  <= lsb_data_d;
            last_if_q   <= last_if_d;
            srv_if_q    <= srv_if_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_inst_q   <= if_inst_d;
            lsb_rdata_q <= lsb_rdata_d;
            if_done_q   <= if_done_d;
            lsb_done_q  <= lsb_done_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;
    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic        if_req_flag = 1'b0, lsb_req_flag = 1'b0, lsb_req_wr = 1'b0;
    logic [31:0] if_req_pc = 32'h0, lsb_req_addr = 32'h0, lsb_req_data = 32'h0;
    logic [1:0]  lsb_req_size = 2'd0;
    logic        rob_flush = 1'b0, io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'h0;
    logic        if_done_flag, lsb_done_flag, mem_wr;
    logic [31:0] if_inst, lsb_rdata, mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  ram [0:262143];
    int          n_cmp = 0, n_bad = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_flag(if_req_flag), .if_req_pc(if_req_pc), .if_done_flag(if_done_flag), .if_inst(if_inst),
        .lsb_req_flag(lsb_req_flag), .lsb_req_wr(lsb_req_wr), .lsb_req_addr(lsb_req_addr),
        .lsb_req_size(lsb_req_size), .lsb_req_data(lsb_req_data),
        .lsb_done_flag(lsb_done_flag), .lsb_rdata(lsb_rdata),
        .rob_flush(rob_flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, frozen with rdy like the controller
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic lsb_pulse(input logic wr, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        lsb_req_flag = 1'b1; lsb_req_wr = wr; lsb_req_addr = a; lsb_req_size = s; lsb_req_data = d;
        @(negedge clk);
        lsb_req_flag = 1'b0;
    endtask

    task automatic if_pulse(input logic [31:0] pc);
        if_req_flag = 1'b1; if_req_pc = pc;
        @(negedge clk);
        if_req_flag = 1'b0;
    endtask

    task automatic wait_lsb(input string nm);
        int n = 0;
        while (!lsb_done_flag && n < 40) begin @(negedge clk); n++; end
        chk({nm, " lsb_done"}, {31'h0, lsb_done_flag}, 32'h1);
    endtask

    task automatic wait_if(input string nm);
        int n = 0;
        while (!if_done_flag && n < 40) begin @(negedge clk); n++; end
        chk({nm, " if_done"}, {31'h0, if_done_flag}, 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n, seen, wrs;
        logic [31:0] wa;
        logic [7:0]  wd;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h0;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05;
        ram[18'h10] = 8'h34; ram[18'h11] = 8'h82; ram[18'h12] = 8'hFF; ram[18'h13] = 8'hFF;
        ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22; ram[0] = 8'h33; ram[1] = 8'h44;
        tbl[0]  = '{1'b1, 32'h400, 2'd2, 32'hA1B2C3D4, 32'h0};
        tbl[1]  = '{1'b0, 32'h400, 2'd2, 32'h0, 32'hA1B2C3D4};
        tbl[2]  = '{1'b0, 32'h400, 2'd0, 32'h0, 32'h000000D4};
        tbl[3]  = '{1'b0, 32'h401, 2'd1, 32'h0, 32'h0000B2C3};
        tbl[4]  = '{1'b0, 32'h403, 2'd0, 32'h0, 32'h000000A1};
        tbl[5]  = '{1'b1, 32'h402, 2'd0, 32'hFFFFFF77, 32'h0};
        tbl[6]  = '{1'b0, 32'h400, 2'd2, 32'h0, 32'hA177C3D4};
        tbl[7]  = '{1'b1, 32'h404, 2'd1, 32'h0000BEEF, 32'h0};
        tbl[8]  = '{1'b0, 32'h403, 2'd2, 32'h0, 32'h00BEEFA1};
        tbl[9]  = '{1'b0, 32'h404, 2'd1, 32'h0, 32'h0000BEEF};
        tbl[10] = '{1'b0, 32'hFFFFFFFE, 2'd2, 32'h0, 32'h44332211};

        repeat (2) @(negedge clk);
        chk("rst mem_a", mem_a, 32'h0);
        chk("rst outs", {27'h0, mem_wr, if_done_flag, lsb_done_flag, |if_inst, |lsb_rdata}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // fetch of 0x100
        if_pulse(32'h100);
        chk("if early done", {31'h0, if_done_flag}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("if mem_a %0d", i), mem_a, 32'h100 + i);
        end
        @(negedge clk);
        chk("if done t6", {31'h0, if_done_flag}, 32'h0);
        @(negedge clk);
        chk("if done t7", {31'h0, if_done_flag}, 32'h1);
        chk("if inst", if_inst, 32'h00000513);
        @(negedge clk);
        chk("if pulse width", {31'h0, if_done_flag}, 32'h0);

        // word store 0xDEADBEEF to 0x200
        lsb_pulse(1'b1, 32'h200, 2'd2, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("st wr %0d", i), {31'h0, mem_wr}, 32'h1);
            chk($sformatf("st a %0d", i), mem_a, 32'h200 + i);
            wd = 8'(32'hDEADBEEF >> (8 * i));
            chk($sformatf("st d %0d", i), {24'h0, mem_dout}, {24'h0, wd});
        end
        @(negedge clk);
        chk("st end wr", {31'h0, mem_wr}, 32'h0);
        chk("st done", {31'h0, lsb_done_flag}, 32'h1);
        chk("st idle a", mem_a, 32'h0);

        // table of loads and stores
        @(negedge clk);
        foreach (tbl[k]) begin
            lsb_pulse(tbl[k].wr, tbl[k].addr, tbl[k].size, tbl[k].data);
            wait_lsb($sformatf("vec %0d", k));
            if (!tbl[k].wr) chk($sformatf("vec %0d rdata", k), lsb_rdata, tbl[k].exp);
            @(negedge clk);
            chk($sformatf("vec %0d pulse", k), {31'h0, lsb_done_flag}, 32'h0);
        end

        // simultaneous requests after reset: LSB wins the first tie
        do_reset();
        if_req_flag = 1'b1; if_req_pc = 32'h100;
        lsb_req_flag = 1'b1; lsb_req_wr = 1'b0; lsb_req_addr = 32'h200; lsb_req_size = 2'd2;
        @(negedge clk);
        if_req_flag = 1'b0; lsb_req_flag = 1'b0;
        @(negedge clk);
        chk("tie lsb first", mem_a, 32'h200);
        repeat (5) @(negedge clk);
        chk("tie lsb done", {31'h0, lsb_done_flag}, 32'h1);
        chk("tie lsb data", lsb_rdata, 32'hDEADBEEF);
        chk("tie idle a", mem_a, 32'h0);
        @(negedge clk);
        chk("tie if next", mem_a, 32'h100);
        wait_if("tie");
        chk("tie if inst", if_inst, 32'h00000513);

        // flush during fetch with a half load queued behind it
        @(negedge clk);
        if_pulse(32'h100);
        lsb_req_flag = 1'b1; lsb_req_wr = 1'b0; lsb_req_addr = 32'h10; lsb_req_size = 2'd1;
        @(negedge clk);
        lsb_req_flag = 1'b0;
        chk("fl if granted", mem_a, 32'h100);
        repeat (2) @(negedge clk);
        chk("fl byte2", mem_a, 32'h102);
        rob_flush = 1'b1;
        @(negedge clk);
        rob_flush = 1'b0;
        chk("fl idle a", mem_a, 32'h0);
        chk("fl wr", {31'h0, mem_wr}, 32'h0);
        seen = {31'h0, if_done_flag};
        @(negedge clk);
        chk("fl lsb granted", mem_a, 32'h10);
        n = 0;
        while (!lsb_done_flag && n < 12) begin
            @(negedge clk);
            n++;
            if (if_done_flag) seen++;
        end
        chk("fl lsb done", {31'h0, lsb_done_flag}, 32'h1);
        chk("fl lsb zext", lsb_rdata, 32'h00008234);
        chk("fl no if_done", seen, 32'h0);
        chk("fl if_inst held", if_inst, 32'h00000513);

        // IO store held off by io_buffer_full
        @(negedge clk);
        io_buffer_full = 1'b1;
        lsb_pulse(1'b1, 32'h30000, 2'd0, 32'h0000005A);
        wrs = 0; wa = 32'h0; wd = 8'h0;
        for (int i = 1; i <= 8; i++) begin
            if (mem_wr) begin wrs++; wa = mem_a; wd = mem_dout; end
            if (i <= 3) chk($sformatf("io held %0d", i), {31'h0, mem_wr}, 32'h0);
            if (i == 3) io_buffer_full = 1'b0;
            @(negedge clk);
        end
        chk("io write count", wrs, 32'd1);
        chk("io write addr", wa, 32'h30000);
        chk("io write data", {24'h0, wd}, 32'h5A);

        // rdy low freezes a load mid-flight
        lsb_pulse(1'b0, 32'h400, 2'd2, 32'h0);
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rdy frozen a", mem_a, 32'h400);
        rdy = 1'b1;
        wait_lsb("rdy");
        chk("rdy rdata", lsb_rdata, 32'hA177C3D4);

        // reset in the middle of a word store
        @(negedge clk);
        lsb_pulse(1'b1, 32'h300, 2'd2, 32'h11223344);
        repeat (2) @(negedge clk);
        chk("rw writing", {31'h0, mem_wr}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("rw async wr", {31'h0, mem_wr}, 32'h0);
        chk("rw async a", mem_a, 32'h0);
        chk("rw async outs", {mem_dout, 19'h0, if_done_flag, lsb_done_flag, 1'b0, |if_inst, |lsb_rdata}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (lsb_done_flag || mem_wr) seen++;
        end
        chk("rw no done", seen, 32'h0);
        lsb_pulse(1'b0, 32'h300, 2'd2, 32'h0);
        wait_lsb("rw load");
        chk("rw partial", lsb_rdata, 32'h00000044);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
